// File: rtl/adder_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-adder
// arbiter. Port 0 is address generation, port 1 is PC increment.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where valid and ready are both high; the sender holds valid and its
// payload stable until that edge, and ready may depend combinationally on
// valid.
interface adder_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             resp0_valid;
    logic [WIDTH-1:0] resp0_sum;
    logic             resp0_ready;
    logic             resp1_valid;
    logic [WIDTH-1:0] resp1_sum;
    logic             resp1_ready;

    // Requester side
    modport master (
        output req0_valid, req0_a, req0_b, input req0_ready,
        output req1_valid, req1_a, req1_b, input req1_ready,
        input  resp0_valid, resp0_sum, output resp0_ready,
        input  resp1_valid, resp1_sum, output resp1_ready
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_a, req0_b, output req0_ready,
        input  req1_valid, req1_a, req1_b, output req1_ready,
        output resp0_valid, resp0_sum, input resp0_ready,
        output resp1_valid, resp1_sum, input resp1_ready
    );
endinterface

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one combinational 16-bit adder between two
// requesters. One transaction in flight: IDLE accepts, ADD drives the adder,
// RESP holds the sum until the owning port acknowledges it.
module adder_arbiter #(
    parameter int WIDTH       = 16,
    parameter bit FIRST_GRANT = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_arbiter_if.slave   bus,
    output logic [WIDTH-1:0] add_in1,
    output logic [WIDTH-1:0] add_in2,
    input  logic [WIDTH-1:0] add_out,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    logic             last_grant_q;
    logic             owner_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum_q;
    logic [1:0]       resp_valid_q;

    logic             grant_hs;
    logic             grant_sel;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic             owner_ack;

    // Port selection in IDLE: a lone requester wins, a tie goes to the port
    // that did not complete last. Held off while reset is asserted.
    always_comb begin
        grant_hs  = 1'b0;
        grant_sel = 1'b0;
        if (rst_n && state_q == IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                grant_hs  = 1'b1;
                grant_sel = ~last_grant_q;
            end else if (bus.req0_valid) begin
                grant_hs  = 1'b1;
                grant_sel = 1'b0;
            end else if (bus.req1_valid) begin
                grant_hs  = 1'b1;
                grant_sel = 1'b1;
            end
        end
    end

    assign bus.req0_ready = grant_hs & ~grant_sel;
    assign bus.req1_ready = grant_hs & grant_sel;
    assign sel_a          = grant_sel ? bus.req1_a : bus.req0_a;
    assign sel_b          = grant_sel ? bus.req1_b : bus.req0_b;
    assign owner_ack      = owner_q ? bus.resp1_ready : bus.resp0_ready;

    // Transaction FSM: accept, add, then hold the response until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= ~FIRST_GRANT;
            owner_q      <= 1'b0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            sum_q        <= '0;
            resp_valid_q <= 2'b00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_hs) begin
                        op_a_q  <= sel_a;
                        op_b_q  <= sel_b;
                        owner_q <= grant_sel;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    sum_q        <= add_out;
                    resp_valid_q <= owner_q ? 2'b10 : 2'b01;
                    state_q      <= RESP;
                end
                RESP: begin
                    if (owner_ack) begin
                        resp_valid_q <= 2'b00;
                        last_grant_q <= owner_q;
                        state_q      <= IDLE;
                    end
                end
                default: begin
                    resp_valid_q <= 2'b00;
                    state_q      <= IDLE;
                end
            endcase
        end
    end

    // The shared adder only sees operands while a sum is being formed.
    assign add_in1 = (state_q == ADD) ? op_a_q : '0;
    assign add_in2 = (state_q == ADD) ? op_b_q : '0;

    assign bus.resp0_valid = resp_valid_q[0];
    assign bus.resp1_valid = resp_valid_q[1];
    assign bus.resp0_sum   = owner_q ? '0 : sum_q;
    assign bus.resp1_sum   = owner_q ? sum_q : '0;
    assign state_o         = state_q;
endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Shares one `adder16` instance between two requesters: the LC-3b address-generation path (port 0) and the PC-increment path (port 1). Each port issues operand pairs through a valid/ready handshake. The arbiter grants round-robin, registers the operands, and drives them into the shared adder. It then captures the 16-bit sum and returns it on that port's response channel, holding it until the port acknowledges.

## Interface
- `WIDTH`, 16, operand/sum width; must match the shared adder (only 16 supported).
- `FIRST_GRANT`, 0, port that wins the first simultaneous request after reset.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req0_valid` in 1: port 0 has an operand pair.
- `req0_a` in WIDTH: port 0 operand A.
- `req0_b` in WIDTH: port 0 operand B.
- `req0_ready` out 1: port 0 operands accepted this cycle.
- `req1_valid`, `req1_a`, `req1_b`, `req1_ready`: same as port 0, for port 1.
- `resp0_valid` out 1: port 0 sum available.
- `resp0_sum` out WIDTH: port 0 sum.
- `resp0_ready` in 1: port 0 consumes the sum.
- `resp1_valid`, `resp1_sum`, `resp1_ready`: same as port 0, for port 1.
- `add_in1` out WIDTH: shared adder operand 1.
- `add_in2` out WIDTH: shared adder operand 2.
- `add_out` in WIDTH: shared adder sum (combinational from `add_in1`/`add_in2`).

## Operation
- FSM states: IDLE, ADD, RESP. One transaction is in flight at a time.
- **IDLE**
  - If exactly one `reqN_valid` is high, that port is selected.
  - If both are high, the port selected is the one not equal to `last_grant`.
  - `reqN_ready` is high only for the selected port. It is combinational from state, both valids and `last_grant`.
  - On handshake: latch `reqN_a` into `op_a`, `reqN_b` into `op_b`, latch N into `owner`, then go to ADD.
  - If no port is valid, stay in IDLE.
- **ADD**
  - `add_in1 = op_a`, `add_in2 = op_b`.
  - At the clock edge, latch `add_out` into `sum_q`, then go to RESP.
- **RESP**
  - `resp<owner>_valid = 1` and `resp<owner>_sum = sum_q`. The other port's `resp_valid` stays 0.
  - When `resp<owner>_ready = 1`: set `last_grant <= owner` and go to IDLE.
  - Otherwise hold state and `sum_q` indefinitely.
- Outside ADD, `add_in1`/`add_in2` = 0.
- Outside RESP, both `resp_valid` = 0.
- `respN_sum` = `sum_q` whenever `owner == N`, otherwise 0.
- Arithmetic is modulo 2^16 with no carry-out (`0xFFFF + 0x0001 = 0x0000`), identical to the shared adder.
- Requesters must hold `valid`/`a`/`b` stable until `ready`. A request dropped before `ready` is never seen.
- `req_ready` is never asserted in ADD or RESP. A new request waits until the next IDLE.

## Timing
- Reset values (asynchronous on `rst_n = 0`): state = IDLE, `last_grant = ~FIRST_GRANT`, `owner = 0`, `op_a = op_b = sum_q = 0`.
- Resulting outputs in reset: all `req_ready`/`resp_valid` 0, all sums 0, `add_in1 = add_in2 = 0`.
- Latency: request handshake at edge T, then ADD during cycle T+1, then `resp_valid` high in cycle T+2.
- Best-case throughput: one transaction per 3 cycles. This holds when `resp_ready` is high in the first RESP cycle.
- `resp_ready` may already be high when `resp_valid` rises. The transaction completes at that edge, and IDLE can accept a request in the next cycle.
- Back-to-back simultaneous requests alternate ports 0, 1, 0, 1… (with `FIRST_GRANT = 0`). Neither port is granted twice while the other is waiting.
- Reset mid-transaction: the operation is discarded, no response is ever issued, and `last_grant` returns to its reset value.
- `resp_ready` on the non-owner port, or in a non-RESP state, is ignored.

## Test plan
- **Single request:** port 0 `a = 0x1234`, `b = 0x0101` → `req0_ready` high in the same cycle; `resp0_valid` with `0x1335` 2 cycles later; `resp1_valid` stays 0.
- **Wrap-around:** port 1 `a = 0xFFFF`, `b = 0x0001` → `resp1_sum = 0x0000`. Also check `0x8000 + 0x8000` → `0x0000`.
- **Contention:** both ports valid continuously from reset with distinct operands → grants alternate 0, 1, 0, 1 for 4 transactions; each sum is correct and on the right port.
- **Backpressure:** hold `resp0_ready = 0` for 5 cycles → `resp0_valid` and the sum stay stable, `req1_ready` stays 0; release → IDLE follows and port 1 is granted.
- **Reset mid-op:** assert `rst_n = 0` during ADD → all outputs 0 immediately and no response afterwards; the first simultaneous request after reset is granted to `FIRST_GRANT`.
- **Immediate ack:** `resp_ready` tied high with a continuous port 0 stream → one result every 3 cycles; `add_in1`/`add_in2` nonzero only during ADD cycles.
